// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU; single-cycle logic/arith, bit-serial shifts, valid/ready on both sides
module alu_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op_type,
  input  logic            unsig,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            lt,
  output logic            eq
);
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SLL = 3'd2, SRL = 3'd3,
                         SRA = 3'd4, XOR = 3'd5, OR  = 3'd6, AND = 3'd7;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] work, shifted, alu_res;
  logic [SHW-1:0]  cnt;
  logic [2:0]      sop;
  logic            acc, is_sh, go_shift, done, lt_c;
  wire  [SHW-1:0]  shamt = src_b[SHW-1:0];
  assign in_ready = rst_n && state == IDLE && (!out_valid || out_ready) && !flush;
  assign acc      = in_valid && in_ready;
  assign is_sh    = op_type == SLL || op_type == SRL || op_type == SRA;
  assign go_shift = acc && is_sh && shamt != '0;
  assign done     = state == SHIFT && cnt == SHW'(1);
  assign lt_c     = unsig ? src_a < src_b : $signed(src_a) < $signed(src_b);
  assign shifted  = sop == SLL ? work << 1 : {sop == SRA && work[XLEN-1], work[XLEN-1:1]};
  always_comb begin
    alu_res = src_a;
    case (op_type)
      ADD:     alu_res = src_a + src_b;
      SUB:     alu_res = src_a - src_b;
      XOR:     alu_res = src_a ^ src_b;
      OR:      alu_res = src_a | src_b;
      AND:     alu_res = src_a & src_b;
      default: alu_res = src_a;
    endcase
  end
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (go_shift) state_nx = SHIFT;
    else if (done) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      cnt       <= '0;
      work      <= '0;
      sop       <= ADD;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (acc) begin
      lt <= lt_c;
      eq <= src_a == src_b;
      if (go_shift) begin
        work      <= src_a;
        cnt       <= shamt;
        sop       <= op_type;
        out_valid <= 1'b0;
      end else begin
        result    <= alu_res;
        out_valid <= 1'b1;
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - 1'b1;
      if (done) begin
        result    <= shifted;
        out_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: randomized + directed bench for alu_exec against a cycle-level behavioural model
module tb_alu_exec;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, unsig = 0, flush = 0;
  logic out_valid, out_ready = 1, lt, eq;
  logic [2:0] op_type = 0;
  logic [31:0] src_a = 0, src_b = 0, result;
  int checks = 0, errors = 0, cyc = 0;
  bit rnd = 0;
  logic [31:0] got[$];

  alu_exec dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_type(op_type), .unsig(unsig), .src_a(src_a), .src_b(src_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .lt(lt), .eq(eq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int k = int'(b[4:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << k;
      3'd3: return a >> k;
      3'd4: return $signed(a) >>> k;
      3'd5: return a ^ b;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic less(input logic u, input logic [31:0] a, input logic [31:0] b);
    return u ? a < b : $signed(a) < $signed(b);
  endfunction

  int m_busy;
  logic m_ov, m_lt, m_eq, m_ready;
  logic [31:0] m_res, m_pend;
  assign m_ready = rst_n && m_busy == 0 && (!m_ov || out_ready) && !flush;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_ov <= 0; m_res <= 0; m_lt <= 0; m_eq <= 0; m_pend <= 0;
    end else if (flush) begin
      m_busy <= 0; m_ov <= 0;
    end else if (in_valid && m_ready) begin
      m_lt <= less(unsig, src_a, src_b);
      m_eq <= src_a == src_b;
      if (op_type inside {3'd2, 3'd3, 3'd4} && src_b[4:0] != 0) begin
        m_busy <= int'(src_b[4:0]); m_pend <= calc(op_type, src_a, src_b); m_ov <= 0;
      end else begin
        m_res <= calc(op_type, src_a, src_b); m_ov <= 1;
      end
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin m_res <= m_pend; m_ov <= 1; end
    end else if (m_ov && out_ready) m_ov <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("result", result, m_res);
    chk("lt", 32'(lt), 32'(m_lt));
    chk("eq", 32'(eq), 32'(m_eq));
    if (out_valid && out_ready && !flush && rst_n) got.push_back(result);
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd) out_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic drive(input logic [2:0] op, input logic u, input logic [31:0] a, input logic [31:0] b);
    logic r;
    int n = 0;
    in_valid = 1; op_type = op; unsig = u; src_a = a; src_b = b;
    forever begin
      @(negedge clk); r = in_ready;
      tick();
      if (r) break;
      if (++n > 200) begin chk("accept_timeout", 32'(n), 0); break; end
    end
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat, input int acc);
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (++n > 200) begin chk("out_timeout", 32'(n), 0); break; end
    end
    lat = cyc - acc;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int lat, t0;
    idle(1);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    rst_n = 1;
    idle(1);
    got.delete();
    drive(3'd0, 0, 32'hFFFF_FFFF, 1); idle(1);
    chk("add_res", got[0], 0);
    chk("add_lt_signed", 32'(lt), 1);
    chk("add_eq", 32'(eq), 0);
    drive(3'd0, 1, 32'hFFFF_FFFF, 1); idle(1);
    chk("add_lt_unsigned", 32'(lt), 0);
    got.delete();
    t0 = cyc;
    drive(3'd1, 0, 5, 7);
    drive(3'd5, 0, 32'hA5A5_A5A5, 32'hFFFF_0000);
    drive(3'd7, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("b2b_cycles", 32'(cyc - t0), 3);
    idle(2);
    chk("b2b_count", 32'(got.size()), 3);
    chk("sub_res", got[0], 32'hFFFF_FFFE);
    chk("xor_res", got[1], 32'h5A5A_A5A5);
    chk("and_res", got[2], 32'h00F0_00F0);
    drive(3'd4, 0, 32'h8000_0000, 32'h24); t0 = cyc; wait_out(lat, t0);
    chk("sra_lat", 32'(lat), 4);
    chk("sra_res", result, 32'hF800_0000);
    drive(3'd3, 0, 32'h8000_0000, 32'h24); t0 = cyc; wait_out(lat, t0);
    chk("srl_res", result, 32'h0800_0000);
    drive(3'd2, 0, 1, 31); t0 = cyc; wait_out(lat, t0);
    chk("sll31_lat", 32'(lat), 31);
    chk("sll31_res", result, 32'h8000_0000);
    drive(3'd2, 0, 32'h1234_5678, 32'h40); t0 = cyc; wait_out(lat, t0);
    chk("sll0_lat", 32'(lat), 0);
    chk("sll0_res", result, 32'h1234_5678);
    idle(1);
    got.delete();
    out_ready = 0;
    drive(3'd6, 0, 1, 2);
    in_valid = 1; op_type = 3'd0; src_a = 9; src_b = 9;
    idle(3);
    chk("hold_res", result, 3);
    chk("hold_ready", 32'(in_ready), 0);
    in_valid = 0; out_ready = 1;
    idle(2);
    chk("hold_count", 32'(got.size()), 1);
    chk("hold_drained", got[0], 3);
    got.delete();
    drive(3'd3, 0, 32'hFFFF_0000, 10);
    idle(4);
    flush = 1; idle(1); flush = 0;
    @(negedge clk);
    chk("flush_ready", 32'(in_ready), 1);
    idle(15);
    chk("flush_noout", 32'(got.size()), 0);
    drive(3'd4, 0, 32'h8000_0000, 20);
    idle(3);
    #2 rst_n = 0;
    #1 chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    tick(); rst_n = 1;
    got.delete();
    drive(3'd0, 0, 2, 3); t0 = cyc; wait_out(lat, t0);
    chk("post_rst_add", result, 5);
    idle(25);
    chk("post_rst_nostale", 32'(got.size()), 1);
    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin flush = 1; tick(); flush = 0; end
      else if ($urandom_range(0, 3) == 0) tick();
      else drive(3'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0 ? 32'(-$urandom_range(0, 4)) : $urandom,
                 $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) : $urandom);
    end
    rnd = 0; out_ready = 1;
    idle(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
